jtag_code_trace_buffer: RTL and testbench
=========================================

# jtag_code_trace_buffer

Capture buffer that sits directly upstream of the 32-bit code input PIO in the JTAG debug system. It records instruction/code words from the core into a small register FIFO. It presents the oldest word as a stable level on `code_out`, which drives the PIO `in_port`. The host controls the buffer through output-PIO level signals: it arms capture, reads the head word through the PIO, and pops with a level toggle.

## Interface
- `DATA_W`, 32, width of a captured code word
- `DEPTH`, 8, FIFO depth in words; must be a power of two, at least 2
- `ADDR_W`, 3, log2(`DEPTH`)
- `clk`  in  1  system clock, the same clock as the PIO; all logic is rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `code_in`  in  `DATA_W`  code word from the core
- `code_valid`  in  1  `code_in` is valid this cycle; single-cycle qualifier
- `arm`  in  1  level from host PIO; capture is enabled while high
- `pop_req`  in  1  level from host PIO; each rising edge pops one word
- `clear`  in  1  level from host PIO; each rising edge flushes the buffer
- `code_out`  out  `DATA_W`  head (oldest) word; 0 when empty; feeds the PIO `in_port`
- `count`  out  `ADDR_W`+1  number of stored words, 0..`DEPTH`
- `empty`  out  1  `count`==0
- `full`  out  1  `count`==`DEPTH`
- `overflow`  out  1  sticky; a valid word was dropped
- `capturing`  out  1  high when the FSM is in CAPTURE

## Operation
- Storage
  - `DEPTH` x `DATA_W` flop array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_W` bits, wrap modulo `DEPTH`.
  - Separate `count` register; `count` is never derived from the pointers.
- Edge detect
  - `pop_q` and `clr_q` are registered copies of `pop_req` and `clear`.
  - pop_pulse = `pop_req` & ~`pop_q`.
  - clr_pulse = `clear` & ~`clr_q`.
- FSM states: IDLE, CAPTURE, HOLD
  - IDLE: no writes. `arm`=1 -> CAPTURE.
  - CAPTURE:
    - write when `code_valid` and (not full, or pop_pulse in the same cycle).
    - `code_valid` while full with no pop: word dropped, `overflow`<=1, go to HOLD.
    - `arm`=0 -> IDLE; a `code_valid` in that same cycle is still written if space allows.
  - HOLD: no writes; further `code_valid` words are ignored and do not touch `overflow`. `arm`=0 -> IDLE.
- Pop
  - pop_pulse with `count`>0: `rd_ptr`+1, `count`-1.
  - pop_pulse with `count`==0: ignored, no state change.
  - Pops are legal in every state.
- Simultaneous write and pop: both occur and `count` is unchanged. This also applies at full, where the write is accepted.
- Clear
  - clr_pulse zeroes the pointers, `count` and `overflow`, and forces the FSM to IDLE.
  - The array contents are left unchanged.
  - Clear has priority over any write or pop in the same cycle.
  - With `arm` still high, the FSM returns to CAPTURE on the next cycle.
- `code_out` = `empty` ? 0 : mem[`rd_ptr`]. It is a mux of flops only, with no combinational path from the inputs.

## Timing
- Reset values:
  - `code_out`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `capturing`=0.
  - FSM in IDLE; pointers 0; `pop_q`=`clr_q`=0.
  - The array is not reset.
- `arm` rising at edge N: `capturing`=1 after edge N. A `code_valid` is first accepted at edge N+1.
- Write at edge N into an empty FIFO: `code_out`, `count` and `empty` are updated immediately after edge N (0-cycle visible latency).
- `pop_req` rising, sampled at edge N: pop happens at edge N and the new head is on `code_out` after edge N. `pop_req` held high causes no further pops.
- Because the PIO samples `in_port` with one register stage, the host sees the new head at least 2 cycles after its pop toggle.
- Reset asserted mid-operation: all state returns to reset values asynchronously. No partial write completes.

## Test plan
- Reset, then `arm`=1 and 3 writes 0x11, 0x22, 0x33:
  - `count`=3 and `code_out`=0x11.
  - Three `pop_req` toggles give `code_out` 0x22, then 0x33, then 0, with `empty`=1.
- Fill 8 words 0xA0..0xA7, then a 9th word 0xFF:
  - `full`=1, `overflow`=1, FSM in HOLD.
  - Popping all 8 yields 0xA0..0xA7 in order; 0xFF is never seen.
- At full in CAPTURE, assert `code_valid`=0xBB and a pop edge in the same cycle:
  - `count` stays 8, `overflow`=0.
  - After 7 more pops, the last word is 0xBB.
- Pointer wrap: 20 write/pop pairs with increasing data. Every pop returns the expected word; `count` alternates between 1 and 0.
- `clear` edge together with `code_valid` at `count`=5:
  - `count`=0, `overflow`=0, `code_out`=0.
  - With `arm` high, `capturing` returns 1 cycle later.
- Assert `reset_n` low mid-capture at `count`=4: all outputs take their reset values immediately, and there are no pops on release.

Source files
------------

// File: rtl/jtag_code_trace_buffer.sv
// jtag_code_trace_buffer
// Captures code words from the core into a small register FIFO.
// The oldest word is presented as a stable level on code_out, which feeds the
// 32-bit code input PIO. The host controls the buffer with PIO level signals:
// arm enables capture, a rising edge on pop_req pops one word, and a rising
// edge on clear flushes the buffer.
module jtag_code_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              arm,
    input  logic              pop_req,
    input  logic              clear,
    output logic [DATA_W-1:0] code_out,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              capturing
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // The pointers wrap naturally only when DEPTH fills the pointer range.
    if ((DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_bad_depth
        $error("jtag_code_trace_buffer: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic                pop_q;
    logic                clr_q;
    logic                pop_pulse;
    logic                clr_pulse;

    logic                is_empty;
    logic                is_full;
    logic                do_pop;
    logic                do_wr;
    logic                do_drop;

    // Rising-edge detection on the host PIO level controls.
    assign pop_pulse = pop_req & ~pop_q;
    assign clr_pulse = clear & ~clr_q;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == FULL_CNT);

    // A pop against an empty buffer is simply ignored.
    assign do_pop  = pop_pulse & ~is_empty;

    // At full a write is still accepted when a pop frees a slot in the same cycle.
    assign do_wr   = (state == ST_CAPTURE) & code_valid & (~is_full | do_pop);

    // A valid word arriving at full with no pop is lost; this is what trips overflow.
    assign do_drop = (state == ST_CAPTURE) & code_valid & is_full & ~pop_pulse;

    // Register the previous level of the host controls for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            pop_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            pop_q <= pop_req;
            clr_q <= clear;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; a clear edge always returns to IDLE.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (arm) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!arm)        state_nxt = ST_IDLE;
                else if (do_drop) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!arm) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clr_pulse) state_nxt = ST_IDLE;
    end

    // FSM outputs.
    always_comb begin
        capturing = (state == ST_CAPTURE);
    end

    // Storage array write; a clear edge suppresses a coincident write.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the count decides which entries are live.
        if (do_wr && !clr_pulse) begin
            mem[wr_ptr] <= code_in;
        end
    end

    // Pointer and occupancy bookkeeping; clear has priority over write and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (clr_pulse) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_wr, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by a clear edge or reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (clr_pulse) begin
            ovf_q <= 1'b0;
        end else if (do_drop) begin
            ovf_q <= 1'b1;
        end
    end

    // Head word and status: driven purely from flops, no path from the inputs.
    assign code_out = is_empty ? '0 : mem[rd_ptr];
    assign count    = cnt_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_jtag_code_trace_buffer.sv
// tb_jtag_code_trace_buffer
// Directed bench for jtag_code_trace_buffer. A queue-based model of the
// buffer tracks what the outputs must be; a compare process checks every
// output against it on each falling edge, and the directed sequence adds
// hand-computed expectations at the points of interest.
module tb_jtag_code_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] code_in;
    logic              code_valid;
    logic              arm;
    logic              pop_req;
    logic              clear;
    logic [DATA_W-1:0] code_out;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              capturing;

    int vectors     = 0;
    int miscompares = 0;

    jtag_code_trace_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .code_in   (code_in),
        .code_valid(code_valid),
        .arm       (arm),
        .pop_req   (pop_req),
        .clear     (clear),
        .code_out  (code_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .capturing (capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 = idle, 1 = capturing, 2 = holding after an overflow.
    logic [DATA_W-1:0] mq[$];
    int                m_mode  = 0;
    bit                m_ovf   = 1'b0;
    bit                m_pop_l = 1'b0;
    bit                m_clr_l = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_mode  = 0;
            m_ovf   = 1'b0;
            m_pop_l = 1'b0;
            m_clr_l = 1'b0;
        end else begin
            bit pop_edge, clr_edge, accept, lost;
            pop_edge = pop_req && !m_pop_l;
            clr_edge = clear && !m_clr_l;
            m_pop_l  = pop_req;
            m_clr_l  = clear;
            if (clr_edge) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_mode = 0;
            end else begin
                accept = (m_mode == 1) && code_valid &&
                         ((mq.size() < DEPTH) || (pop_edge && mq.size() > 0));
                lost   = (m_mode == 1) && code_valid && (mq.size() == DEPTH) && !pop_edge;
                if (pop_edge && mq.size() > 0) void'(mq.pop_front());
                if (accept) mq.push_back(code_in);
                if (lost) m_ovf = 1'b1;
                case (m_mode)
                    0:       if (arm) m_mode = 1;
                    1:       if (!arm) m_mode = 0; else if (lost) m_mode = 2;
                    default: if (!arm) m_mode = 0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        check("m_code_out",  64'(code_out),  (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
        check("m_count",     64'(count),     64'(mq.size()));
        check("m_empty",     64'(empty),     64'(mq.size() == 0));
        check("m_full",      64'(full),      64'(mq.size() == DEPTH));
        check("m_overflow",  64'(overflow),  64'(m_ovf));
        check("m_capturing", 64'(capturing), 64'(m_mode == 1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        code_in    = d;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic pop_word();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        code_in    = '0;
        code_valid = 1'b0;
        arm        = 1'b0;
        pop_req    = 1'b0;
        clear      = 1'b0;
        tick(2);
        check("rst_code_out",  64'(code_out),  64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_capturing", 64'(capturing), 64'd0);
        reset_n = 1'b1;
        tick();

        // Three writes then three pops.
        arm = 1'b1;
        tick();
        check("arm_capturing", 64'(capturing), 64'd1);
        write_word(32'h11);
        write_word(32'h22);
        write_word(32'h33);
        check("w3_count", 64'(count),    64'd3);
        check("w3_head",  64'(code_out), 64'h11);
        pop_word();
        check("p1_head", 64'(code_out), 64'h22);
        pop_word();
        check("p2_head", 64'(code_out), 64'h33);
        pop_word();
        check("p3_head",  64'(code_out), 64'd0);
        check("p3_empty", 64'(empty),    64'd1);

        // Fill to full, then a ninth word is dropped.
        for (int i = 0; i < 8; i++) write_word(32'hA0 + 32'(i));
        write_word(32'hFF);
        check("ovf_full",      64'(full),      64'd1);
        check("ovf_flag",      64'(overflow),  64'd1);
        check("ovf_hold",      64'(capturing), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", 64'(code_out), 64'hA0 + 64'(i));
            pop_word();
        end
        check("ovf_empty", 64'(empty), 64'd1);

        // Leave HOLD, clear the sticky flag, re-arm.
        arm = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        check("clr_ovf", 64'(overflow), 64'd0);
        arm = 1'b1;
        tick();

        // Write and pop together at full.
        for (int i = 0; i < 8; i++) write_word(32'hC0 + 32'(i));
        code_in    = 32'hBB;
        code_valid = 1'b1;
        pop_req    = 1'b1;
        tick();
        code_valid = 1'b0;
        pop_req    = 1'b0;
        check("wp_count", 64'(count),    64'd8);
        check("wp_ovf",   64'(overflow), 64'd0);
        check("wp_head",  64'(code_out), 64'hC1);
        tick();
        for (int i = 0; i < 7; i++) pop_word();
        check("wp_last",  64'(code_out), 64'hBB);
        check("wp_cnt1",  64'(count),    64'd1);
        pop_word();
        check("wp_empty", 64'(empty), 64'd1);

        // Pointer wrap with write/pop pairs.
        for (int i = 0; i < 20; i++) begin
            write_word(32'h100 + 32'(i));
            check("wrap_head", 64'(code_out), 64'h100 + 64'(i));
            check("wrap_c1",   64'(count),    64'd1);
            pop_word();
            check("wrap_c0",   64'(count),    64'd0);
        end

        // Clear edge together with a valid word at count 5.
        for (int i = 0; i < 5; i++) write_word(32'h200 + 32'(i));
        check("cl_count5", 64'(count), 64'd5);
        code_in    = 32'h77;
        code_valid = 1'b1;
        clear      = 1'b1;
        tick();
        code_valid = 1'b0;
        clear      = 1'b0;
        check("cl_count", 64'(count),     64'd0);
        check("cl_ovf",   64'(overflow),  64'd0);
        check("cl_head",  64'(code_out),  64'd0);
        check("cl_idle",  64'(capturing), 64'd0);
        tick();
        check("cl_recap", 64'(capturing), 64'd1);

        // Asynchronous reset in the middle of capture.
        for (int i = 0; i < 4; i++) write_word(32'h300 + 32'(i));
        check("ar_count4", 64'(count), 64'd4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("ar_count", 64'(count),     64'd0);
        check("ar_empty", 64'(empty),     64'd1);
        check("ar_head",  64'(code_out),  64'd0);
        check("ar_cap",   64'(capturing), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("ar_post_count", 64'(count), 64'd0);
        write_word(32'h5A);
        check("ar_post_head", 64'(code_out), 64'h5A);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
